// File: rtl/pid_sched_pkg.sv
// pid_sched_pkg: shared types, widths and saturation helpers for the pid_sched
// scheduler. The saturation helpers clamp to the default error/integrator widths.
package pid_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int KP_W   = 3;
  localparam int KI_W   = 4;
  localparam int KD_W   = 3;
  localparam int PID_EW = 9;
  localparam int PID_IW = 14;

  // Clamp a wide signed value into the signed integrator range.
  function automatic logic signed [31:0] sat_IW(input logic signed [31:0] x);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (PID_IW - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (PID_IW - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

  // Clamp a wide signed value into the signed error range.
  function automatic logic signed [31:0] sat_EW(input logic signed [31:0] x);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (PID_EW - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (PID_EW - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/pid_sched_engine.sv
// pid_engine: combinational PID step from registered operands to the new
// integrator value and the clipped output code. The derivative term exists
// only when PID_SCHED_DERIV_EN is defined.
module pid_engine
  import pid_sched_pkg::*;
#(
  parameter int EW = PID_EW,
  parameter int IW = PID_IW,
  parameter int UW = PID_IW - 3
) (
`ifdef PID_SCHED_DERIV_EN
  input  logic signed [EW-1:0]   e1,
  input  logic signed [KD_W-1:0] kd,
`endif
  input  logic signed [EW-1:0]   e,
  input  logic signed [KP_W-1:0] kp,
  input  logic signed [KI_W-1:0] ki,
  input  logic signed [IW-1:0]   ui1,
  output logic signed [IW-1:0]   ui,
  output logic        [UW-1:0]   u
);

  logic signed [31:0]   up;
  logic signed [31:0]   wi;
  logic signed [31:0]   ud;
  logic signed [IW-1:0] ui_w;
  logic signed [IW-1:0] s;

  // Products and sums are carried at 32 bits, wider than any intermediate,
  // so nothing truncates before the final saturation.
  always_comb begin
    up   = 32'(kp) * 32'(e);
    wi   = 32'(ki) * 32'(e);
    ui_w = IW'(sat_IW(32'(ui1) + wi));
`ifdef PID_SCHED_DERIV_EN
    ud   = 32'(kd) * sat_EW(32'(e) - 32'(e1));
`else
    ud   = '0;
`endif
    s    = IW'(sat_IW(up + 32'(ui_w) + ud));
    ui   = ui_w;
    u    = s[IW-1] ? '0 : UW'(s >>> 3);
  end

endmodule

// File: rtl/pid_sched.sv
// pid_sched: round-robin scheduler stepping N_CH PID loops through one shared
// engine, two cycles per enabled channel. Define PID_SCHED_DERIV_EN to build
// the derivative path and per-channel previous-error storage.
module pid_sched
  import pid_sched_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int EW   = PID_EW,
  parameter int IW   = PID_IW,
  parameter int UW   = PID_IW - 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_i,
  input  logic [N_CH*EW-1:0]   e_i,
  input  logic [KP_W*N_CH-1:0] kp_i,
  input  logic [KI_W*N_CH-1:0] ki_i,
  input  logic [KD_W*N_CH-1:0] kd_i,
  input  logic [N_CH-1:0]      ch_en_i,
  input  logic                 int_clr_i,
  output logic [N_CH*UW-1:0]   u_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 overrun_o
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t               state, state_nx;
  logic [N_CH-1:0]      mask_q;
  logic [CW-1:0]        ptr;
  logic [CW-1:0]        nxt_ch, first_ch;
  logic                 nxt_vld;
  logic                 clr_pend, clr_now;
  logic signed [IW-1:0] ui1_q [N_CH];
  logic [UW-1:0]        u_q [N_CH];

  logic signed [EW-1:0]   op_e_p0;
  logic signed [KP_W-1:0] op_kp_p0;
  logic signed [KI_W-1:0] op_ki_p0;
  logic signed [IW-1:0]   op_ui1_p0;
  logic signed [IW-1:0]   eng_ui;
  logic [UW-1:0]          eng_u;

`ifdef PID_SCHED_DERIV_EN
  logic signed [EW-1:0]   e1_q [N_CH];
  logic signed [EW-1:0]   op_e1_p0;
  logic signed [KD_W-1:0] op_kd_p0;
`else
  logic unused_kd;
  assign unused_kd = ^kd_i;
`endif

  // Lowest enabled channel above the pointer, and lowest channel of the new mask.
  always_comb begin
    nxt_vld  = 1'b0;
    nxt_ch   = '0;
    first_ch = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (mask_q[k] && (k > int'(ptr))) begin
        nxt_vld = 1'b1;
        nxt_ch  = CW'(k);
      end
      if (ch_en_i[k]) first_ch = CW'(k);
    end
  end

  // Integrator clear happens immediately when idle, otherwise at round end.
  assign clr_now = ((state == IDLE) && int_clr_i) ||
                   ((state == DONE) && (clr_pend || int_clr_i));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_i) state_nx = (|ch_en_i) ? FETCH : DONE;
      FETCH:   state_nx = EXEC;
      EXEC:    state_nx = nxt_vld ? FETCH : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_o = (state != IDLE);
    done_o = (state == DONE);
  end

  // Round control: latched mask, channel pointer, deferred clear, overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      ptr       <= '0;
      clr_pend  <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if ((state == IDLE) && sample_i) begin
        mask_q <= ch_en_i;
        ptr    <= first_ch;
      end else if (state == EXEC) begin
        ptr <= nxt_ch;
      end
      if (state == DONE)                                      clr_pend <= 1'b0;
      else if (int_clr_i && ((state == FETCH) || (state == EXEC))) clr_pend <= 1'b1;
      if (sample_i && (state != IDLE)) overrun_o <= 1'b1;
      else if (clr_now)                overrun_o <= 1'b0;
    end
  end

  // ---- stage p0: operand fetch for the channel under the pointer ----
  // Operand registers carry data only and are always reloaded before use.
  always_ff @(posedge clk) begin
    if (state == FETCH) begin
      op_e_p0   <= e_i[ptr*EW +: EW];
      op_kp_p0  <= kp_i[ptr*KP_W +: KP_W];
      op_ki_p0  <= ki_i[ptr*KI_W +: KI_W];
      op_ui1_p0 <= ui1_q[ptr];
`ifdef PID_SCHED_DERIV_EN
      op_e1_p0  <= e1_q[ptr];
      op_kd_p0  <= kd_i[ptr*KD_W +: KD_W];
`endif
    end
  end

  // ---- execute: shared engine evaluates the fetched operands ----
  pid_engine #(.EW(EW), .IW(IW), .UW(UW)) u_engine (
`ifdef PID_SCHED_DERIV_EN
    .e1  (op_e1_p0),
    .kd  (op_kd_p0),
`endif
    .e   (op_e_p0),
    .kp  (op_kp_p0),
    .ki  (op_ki_p0),
    .ui1 (op_ui1_p0),
    .ui  (eng_ui),
    .u   (eng_u)
  );

  // Per-channel loop state: written back at EXEC, zeroed on a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        ui1_q[k] <= '0;
`ifdef PID_SCHED_DERIV_EN
        e1_q[k]  <= '0;
`endif
      end
    end else if (clr_now) begin
      for (int k = 0; k < N_CH; k++) begin
        ui1_q[k] <= '0;
`ifdef PID_SCHED_DERIV_EN
        e1_q[k]  <= '0;
`endif
      end
    end else if (state == EXEC) begin
      ui1_q[ptr] <= eng_ui;
`ifdef PID_SCHED_DERIV_EN
      e1_q[ptr]  <= op_e_p0;
`endif
    end
  end

  // Output registers hold their value until the channel is executed again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) u_q[k] <= '0;
    end else if (state == EXEC) begin
      u_q[ptr] <= eng_u;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_uo
    assign u_o[g*UW +: UW] = u_q[g];
  end

endmodule
